// File: rtl/merge_rr_if.sv
// Native-bus bundle around merge_rr: N packed master ports plus one slave port.
// The slave modport is the merger's view; master is the surrounding agents' view.
interface merge_rr_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]          m_valid;
    logic [N_MASTERS*ADDR_W-1:0]   m_addr;
    logic [N_MASTERS*DATA_W-1:0]   m_wdata;
    logic [N_MASTERS*DATA_W/8-1:0] m_wstrb;
    logic [DATA_W-1:0]             m_rdata;
    logic [N_MASTERS-1:0]          m_ready;
    logic                          s_valid;
    logic [ADDR_W-1:0]             s_addr;
    logic [DATA_W-1:0]             s_wdata;
    logic [DATA_W/8-1:0]           s_wstrb;
    logic [DATA_W-1:0]             s_rdata;
    logic                          s_ready;
    logic [N_MASTERS-1:0]          gnt;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
        output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, gnt
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
        input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, gnt
    );
endinterface

// File: rtl/merge_rr.sv
// Round-robin merger of N native-bus masters onto one memory slave.
// One IDLE bubble between grants; completion is passed through combinationally.
module merge_rr #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input logic       clk,
    input logic       rst,
    merge_rr_if.slave bus
);
    localparam int SW = DATA_W / 8;
    localparam int IW = $clog2(N_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] grant;
    logic [IW-1:0] grant_nx;
    logic [IW-1:0] last;
    logic [IW-1:0] last_nx;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          pick_ok;
    logic          busy;

    // First requester searching upward from last+1; lowest offset wins.
    always_comb begin
        pick    = last;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N_MASTERS);
            if (bus.m_valid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(N_MASTERS - 1);
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            last  <= last_nx;
        end
    end

    // Next state: arbitrate in IDLE, finish on ready or abandoned request.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nx = BUSY;
                    grant_nx = pick;
                end
            end
            BUSY: begin
                if (bus.s_ready) begin
                    state_nx = IDLE;
                    last_nx  = grant;
                end else if (!bus.m_valid[grant]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: route the granted master to the slave, reply to it alone.
    always_comb begin
        busy         = (state == BUSY);
        bus.s_valid  = busy & bus.m_valid[grant];
        bus.s_addr   = bus.m_addr[int'(grant)*ADDR_W +: ADDR_W];
        bus.s_wdata  = bus.m_wdata[int'(grant)*DATA_W +: DATA_W];
        bus.s_wstrb  = bus.m_wstrb[int'(grant)*SW +: SW];
        bus.m_rdata  = bus.s_rdata;
        bus.gnt      = '0;
        bus.m_ready  = '0;
        if (busy) begin
            bus.gnt[grant] = 1'b1;
            if (bus.s_ready && !rst) begin
                bus.m_ready[grant] = 1'b1;
            end
        end
    end
endmodule
